// File: rtl/dm_load_unit.sv
// dm_load_unit: single-outstanding load unit between the MEM stage and the
// data-memory/bridge read port. Issues a word-aligned read, waits for the
// return (bounded by TIMEOUT), then extracts and extends the addressed
// byte/halfword. Misaligned loads and bus timeouts are reported on rsp_exc.
module dm_load_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mod,
  input  logic [4:0]  req_tag,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic [1:0]  rsp_exc
);

  localparam logic [2:0] MOD_LW  = 3'd1;
  localparam logic [2:0] MOD_LH  = 3'd2;
  localparam logic [2:0] MOD_LHU = 3'd3;
  localparam logic [2:0] MOD_LB  = 3'd4;
  localparam logic [2:0] MOD_LBU = 3'd5;

  localparam logic [1:0] EXC_OK      = 2'd0;
  localparam logic [1:0] EXC_MISALGN = 2'd1;
  localparam logic [1:0] EXC_TIMEOUT = 2'd2;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic [2:0]  mod_q, mod_d;
  logic [1:0]  off_q, off_d;
  logic        rd_en_d;
  logic [31:0] addr_d;
  logic        rsp_valid_d;
  logic [31:0] data_d;
  logic [4:0]  tag_d;
  logic [1:0]  exc_d;

  // Select the addressed byte/halfword from the returned word and extend it.
  function automatic logic [31:0] extract(input logic [2:0] m,
                                          input logic [1:0] k,
                                          input logic [31:0] w);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = k[1] ? w[31:16] : w[15:0];
    case (k)
      2'd0:    byte_v = w[7:0];
      2'd1:    byte_v = w[15:8];
      2'd2:    byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    case (m)
      MOD_LW:  extract = w;
      MOD_LH:  extract = {{16{half[15]}}, half};
      MOD_LHU: extract = {16'h0000, half};
      MOD_LB:  extract = {{24{byte_v[7]}}, byte_v};
      MOD_LBU: extract = {24'h000000, byte_v};
      default: extract = 32'h0000_0000;
    endcase
  endfunction

  // Only IDLE accepts; decoded from the state register alone.
  assign req_ready = (state == IDLE);

  // Next-state and next-output decode for the IDLE/WAIT/RESP controller.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state;
    cnt_d       = cnt;
    mod_d       = mod_q;
    off_d       = off_q;
    rd_en_d     = 1'b0;
    addr_d      = mem_addr;
    rsp_valid_d = rsp_valid;
    data_d      = rsp_data;
    tag_d       = rsp_tag;
    exc_d       = rsp_exc;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          mod_d  = req_mod;
          off_d  = req_addr[1:0];
          tag_d  = req_tag;
          addr_d = {req_addr[31:2], 2'b00};
          cnt_d  = 8'd0;
          case (req_mod)
            MOD_LW, MOD_LH, MOD_LHU, MOD_LB, MOD_LBU: begin
              if ((req_mod == MOD_LW && req_addr[1:0] != 2'b00) ||
                  ((req_mod == MOD_LH || req_mod == MOD_LHU) && req_addr[0])) begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                data_d      = 32'h0000_0000;
                exc_d       = EXC_MISALGN;
              end else begin
                state_d = WAIT;
                rd_en_d = 1'b1;
              end
            end
            default: begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              data_d      = 32'h0000_0000;
              exc_d       = EXC_OK;
            end
          endcase
        end
      end
      WAIT: begin
        cnt_d = cnt + 8'd1;
        // Data return wins over a timeout reached in the same cycle.
        if (mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          data_d      = extract(mod_q, off_q, mem_rdata);
          exc_d       = EXC_OK;
        end else if (cnt + 8'd1 == TMO) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          data_d      = 32'h0000_0000;
          exc_d       = EXC_TIMEOUT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      // NOTE: every register here is small control/output state, so all of it
      // is reset; an abandoned in-flight read simply drops with the state.
      state     <= IDLE;
      cnt       <= 8'd0;
      mod_q     <= 3'd0;
      off_q     <= 2'd0;
      mem_rd_en <= 1'b0;
      mem_addr  <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0000_0000;
      rsp_tag   <= 5'd0;
      rsp_exc   <= EXC_OK;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      mod_q     <= mod_d;
      off_q     <= off_d;
      mem_rd_en <= rd_en_d;
      mem_addr  <= addr_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= data_d;
      rsp_tag   <= tag_d;
      rsp_exc   <= exc_d;
    end
  end

endmodule
